// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter/sequencer sharing one AES core between two requesters,
// with scope trigger generation and start/finish watchdogs.
module aes_core_arbiter #(
  parameter int START_WAIT  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_i,
  input  logic [127:0] data0_i,
  input  logic [127:0] data1_i,
  output logic [1:0]   gnt_o,
  output logic [1:0]   done_o,
  output logic         err_o,
  output logic [127:0] result_o,
  output logic         busy_o,
  output logic         trig_o,
  output logic         aes_load_o,
  output logic [127:0] aes_data_o,
  input  logic         aes_busy_i,
  input  logic [127:0] aes_data_i
);

  localparam int CNT_MAX = (START_WAIT > TIMEOUT_CYC) ? START_WAIT : TIMEOUT_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DONE
  } state_e;

  state_e         state_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           last_q;
  logic           err_q;
  logic           errOut_q;
  logic           trig_q;
  logic           load_q;
  logic           busy_q;
  logic [1:0]     gnt_q;
  logic [1:0]     done_q;
  logic [127:0]   result_q;
  logic [127:0]   aesData_q;
  logic           grantB_d;

  // B wins when it is the only requester, or on a tie when A was served last.
  always_comb begin
    grantB_d = (req_i == 2'b10) || ((req_i == 2'b11) && !last_q);
    cnt_d    = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      err_q     <= 1'b0;
      errOut_q  <= 1'b0;
      trig_q    <= 1'b0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      gnt_q     <= 2'b00;
      done_q    <= 2'b00;
      result_q  <= '0;
      aesData_q <= '0;
    end else begin
      gnt_q  <= 2'b00;
      done_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            gnt_q     <= grantB_d ? 2'b10 : 2'b01;
            aesData_q <= grantB_d ? data1_i : data0_i;
            load_q    <= 1'b1;
            trig_q    <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            last_q    <= grantB_d;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          load_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= START;
        end
        START: begin
          if (aes_busy_i) begin
            cnt_q   <= '0;
            state_q <= RUN;
          end else if (cnt_q == CW'(START_WAIT)) begin
            err_q   <= 1'b1;
            trig_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RUN: begin
          if (!aes_busy_i) begin
            result_q <= aes_data_i;
            err_q    <= 1'b0;
            trig_q   <= 1'b0;
            state_q  <= DONE;
          end else if (cnt_q == CW'(TIMEOUT_CYC)) begin
            err_q   <= 1'b1;
            trig_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          done_q   <= last_q ? 2'b10 : 2'b01;
          errOut_q <= err_q;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = errOut_q;
  assign result_o   = result_q;
  assign busy_o     = busy_q;
  assign trig_o     = trig_q;
  assign aes_load_o = load_q;
  assign aes_data_o = aesData_q;

endmodule
